// File: rtl/csc_sm_term_gen_pkg.sv
// Shared widths and sign-magnitude helpers for the colour-space-conversion term generator.
package csc_sm_term_gen_pkg;

    localparam int SM_W      = 25;
    localparam int MAG_W     = 24;
    localparam int COEF_W    = 17;
    localparam int CMAG_W    = 16;
    localparam int PIX_W     = 8;
    localparam int NIB_W     = 4;
    localparam int PP_W      = 20;
    localparam int FRAC_BITS = 12;
    localparam int LATENCY   = 3;

    // A zero magnitude always carries a positive sign so downstream never sees -0.
    function automatic logic [SM_W-1:0] sm_pack(input logic sgn, input logic [MAG_W-1:0] mag);
        return {sgn & (|mag), mag};
    endfunction

endpackage

// File: rtl/csc_sm_term_gen_if.sv
// Pixel/coefficient/offset bus into the term generator and the four aligned terms out of it.
interface csc_sm_term_gen_if #(
    parameter int DELAY_DATA_WIDTH = 16
);
    import csc_sm_term_gen_pkg::*;

    logic                        valid_in;
    logic [PIX_W-1:0]            pix_1;
    logic [PIX_W-1:0]            pix_2;
    logic [PIX_W-1:0]            pix_3;
    logic [COEF_W-1:0]           coef_1;
    logic [COEF_W-1:0]           coef_2;
    logic [COEF_W-1:0]           coef_3;
    logic [SM_W-1:0]             offset;
    logic                        coef_load;
    logic [DELAY_DATA_WIDTH-1:0] ddata_in;

    logic                        valid_out;
    logic [SM_W-1:0]             data_1;
    logic [SM_W-1:0]             data_2;
    logic [SM_W-1:0]             data_3;
    logic [SM_W-1:0]             data_4;
    logic [DELAY_DATA_WIDTH-1:0] ddata_out;

    modport master (
        output valid_in, pix_1, pix_2, pix_3, coef_1, coef_2, coef_3, offset, coef_load, ddata_in,
        input  valid_out, data_1, data_2, data_3, data_4, ddata_out
    );

    modport slave (
        input  valid_in, pix_1, pix_2, pix_3, coef_1, coef_2, coef_3, offset, coef_load, ddata_in,
        output valid_out, data_1, data_2, data_3, data_4, ddata_out
    );

endinterface

// File: rtl/csc_sm_term_gen_mul.sv
// Three-stage unsigned pixel x sign-magnitude coefficient multiplier built from two nibble partial products.
module csc_sm_mul
    import csc_sm_term_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [PIX_W-1:0]  i_pix,
    input  logic [COEF_W-1:0] i_coef,
    output logic [SM_W-1:0]   o_data
);

    logic [PIX_W-1:0]  r_pix_p0;
    logic [CMAG_W-1:0] r_mag_p0;
    logic              r_sgn_p0;
    logic [PP_W-1:0]   r_lo_p1;
    logic [PP_W-1:0]   r_hi_p1;
    logic              r_sgn_p1;
    logic [SM_W-1:0]   r_data_p2;
    logic [PP_W-1:0]   w_lo;
    logic [PP_W-1:0]   w_hi;
    logic [MAG_W-1:0]  w_mag;

    assign w_lo  = {{(PP_W-NIB_W){1'b0}}, r_pix_p0[NIB_W-1:0]} * {{(PP_W-CMAG_W){1'b0}}, r_mag_p0};
    assign w_hi  = {{(PP_W-NIB_W){1'b0}}, r_pix_p0[PIX_W-1:NIB_W]} * {{(PP_W-CMAG_W){1'b0}}, r_mag_p0};
    // 0xFF * 0xFFFF = 0xFEFF01 fits in 24 bits, so the recombination needs no carry out.
    assign w_mag = {{(MAG_W-PP_W){1'b0}}, r_lo_p1} + {r_hi_p1, {NIB_W{1'b0}}};

    // Stage p0: operand capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pix_p0 <= '0;
            r_mag_p0 <= '0;
            r_sgn_p0 <= 1'b0;
        end else begin
            r_pix_p0 <= i_pix;
            r_mag_p0 <= i_coef[CMAG_W-1:0];
            r_sgn_p0 <= i_coef[COEF_W-1];
        end
    end

    // Stage p1: nibble partial products
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lo_p1  <= '0;
            r_hi_p1  <= '0;
            r_sgn_p1 <= 1'b0;
        end else begin
            r_lo_p1  <= w_lo;
            r_hi_p1  <= w_hi;
            r_sgn_p1 <= r_sgn_p0;
        end
    end

    // Stage p2: recombine and pack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_p2 <= '0;
        end else begin
            r_data_p2 <= sm_pack(r_sgn_p1, w_mag);
        end
    end

    assign o_data = r_data_p2;

endmodule

// File: rtl/csc_sm_term_gen.sv
// Producer of the four sign-magnitude terms for the CSC adder; fixed 3-clock latency.
// Optional macro CSC_COEF_LATCH_EN: coefficients/offset come from shadow registers loaded by coef_load.
module csc_sm_term_gen
    import csc_sm_term_gen_pkg::*;
#(
    parameter int DELAY_DATA_WIDTH = 16
) (
    input logic               clk,
    input logic               rstn,
    csc_sm_term_gen_if.slave  bus
);

    logic [COEF_W-1:0]           w_coef_1;
    logic [COEF_W-1:0]           w_coef_2;
    logic [COEF_W-1:0]           w_coef_3;
    logic [SM_W-1:0]             w_offset;

    logic [SM_W-1:0]             r_off_p0;
    logic [SM_W-1:0]             r_off_p1;
    logic [SM_W-1:0]             r_off_p2;
    logic [DELAY_DATA_WIDTH-1:0] r_dd_p0;
    logic [DELAY_DATA_WIDTH-1:0] r_dd_p1;
    logic [DELAY_DATA_WIDTH-1:0] r_dd_p2;
    logic                        r_vld_p0;
    logic                        r_vld_p1;
    logic                        r_vld_p2;

`ifdef CSC_COEF_LATCH_EN
    logic [COEF_W-1:0] r_coef_1_sh;
    logic [COEF_W-1:0] r_coef_2_sh;
    logic [COEF_W-1:0] r_coef_3_sh;
    logic [SM_W-1:0]   r_offset_sh;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_coef_1_sh <= '0;
            r_coef_2_sh <= '0;
            r_coef_3_sh <= '0;
            r_offset_sh <= '0;
        end else if (bus.coef_load) begin
            r_coef_1_sh <= bus.coef_1;
            r_coef_2_sh <= bus.coef_2;
            r_coef_3_sh <= bus.coef_3;
            r_offset_sh <= bus.offset;
        end
    end

    assign w_coef_1 = r_coef_1_sh;
    assign w_coef_2 = r_coef_2_sh;
    assign w_coef_3 = r_coef_3_sh;
    assign w_offset = r_offset_sh;
`else
    logic w_unused_coef_load;

    assign w_unused_coef_load = bus.coef_load;
    assign w_coef_1 = bus.coef_1;
    assign w_coef_2 = bus.coef_2;
    assign w_coef_3 = bus.coef_3;
    assign w_offset = bus.offset;
`endif

    csc_sm_mul u_mul_1 (.clk(clk), .rstn(rstn), .i_pix(bus.pix_1), .i_coef(w_coef_1), .o_data(bus.data_1));
    csc_sm_mul u_mul_2 (.clk(clk), .rstn(rstn), .i_pix(bus.pix_2), .i_coef(w_coef_2), .o_data(bus.data_2));
    csc_sm_mul u_mul_3 (.clk(clk), .rstn(rstn), .i_pix(bus.pix_3), .i_coef(w_coef_3), .o_data(bus.data_3));

    // Stages p0..p2: offset, side-band and valid delay lines matching the multipliers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_off_p0 <= '0;
            r_off_p1 <= '0;
            r_off_p2 <= '0;
            r_dd_p0  <= '0;
            r_dd_p1  <= '0;
            r_dd_p2  <= '0;
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_off_p0 <= w_offset;
            r_off_p1 <= r_off_p0;
            r_off_p2 <= sm_pack(r_off_p1[SM_W-1], r_off_p1[MAG_W-1:0]);
            r_dd_p0  <= bus.ddata_in;
            r_dd_p1  <= r_dd_p0;
            r_dd_p2  <= r_dd_p1;
            r_vld_p0 <= bus.valid_in;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign bus.data_4    = r_off_p2;
    assign bus.ddata_out = r_dd_p2;
    assign bus.valid_out = r_vld_p2;

endmodule

// File: tb/tb_csc_sm_term_gen.sv
// Scoreboard bench for csc_sm_term_gen: directed term vectors, side-band stream, mid-stream reset.
module tb_csc_sm_term_gen;

    typedef struct {
        logic [7:0]  p1;
        logic [16:0] c1;
        logic [7:0]  p2;
        logic [16:0] c2;
        logic [7:0]  p3;
        logic [16:0] c3;
        logic [24:0] off;
        logic [24:0] e1;
        logic [24:0] e2;
        logic [24:0] e3;
        logic [24:0] e4;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [24:0] d1;
        logic [24:0] d2;
        logic [24:0] d3;
        logic [24:0] d4;
        logic [15:0] dd;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t q[$];
    vec_t tab[5];

    csc_sm_term_gen_if #(.DELAY_DATA_WIDTH(16)) bus();

    csc_sm_term_gen #(.DELAY_DATA_WIDTH(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.valid_out === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency_cycle", cyc, e.cyc);
                check("data_1", {7'd0, bus.data_1}, {7'd0, e.d1});
                check("data_2", {7'd0, bus.data_2}, {7'd0, e.d2});
                check("data_3", {7'd0, bus.data_3}, {7'd0, e.d3});
                check("data_4", {7'd0, bus.data_4}, {7'd0, e.d4});
                check("ddata_out", {16'd0, bus.ddata_out}, {16'd0, e.dd});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coefs(input vec_t v);
        bus.coef_1 = v.c1;
        bus.coef_2 = v.c2;
        bus.coef_3 = v.c3;
        bus.offset = v.off;
    endtask

    task automatic push(input vec_t v, input logic [15:0] dd);
        exp_t e;
        e.cyc = cyc + 3;
        e.d1  = v.e1;
        e.d2  = v.e2;
        e.d3  = v.e3;
        e.d4  = v.e4;
        e.dd  = dd;
        q.push_back(e);
    endtask

    task automatic issue(input vec_t v, input bit do_load, input logic [15:0] dd);
        if (do_load) begin
            drive_coefs(v);
            bus.coef_load = 1'b1;
            bus.valid_in  = 1'b0;
            step();
            bus.coef_load = 1'b0;
        end
        drive_coefs(v);
        bus.pix_1    = v.p1;
        bus.pix_2    = v.p2;
        bus.pix_3    = v.p3;
        bus.ddata_in = dd;
        bus.valid_in = 1'b1;
        push(v, dd);
        step();
        bus.valid_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_out"}, {31'd0, bus.valid_out}, 32'd0);
        check({tag, "_data_1"}, {7'd0, bus.data_1}, 32'd0);
        check({tag, "_data_2"}, {7'd0, bus.data_2}, 32'd0);
        check({tag, "_data_3"}, {7'd0, bus.data_3}, 32'd0);
        check({tag, "_data_4"}, {7'd0, bus.data_4}, 32'd0);
        check({tag, "_ddata_out"}, {16'd0, bus.ddata_out}, 32'd0);
    endtask

    // Stream: pixel i, coef_1=+1.0, coef_2=-2/4096, coef_3=0, offset fixed; valid on even i only.
    task automatic stream(input int n, input int reset_at);
        vec_t s;
        s = '{8'h00, 17'h01000, 8'h00, 17'h10002, 8'h00, 17'h00000, 25'h0000123,
              25'h0, 25'h0, 25'h0, 25'h0000123};
        issue_load_only(s);
        for (int i = 0; i < n; i++) begin
            if (i == reset_at) begin
                #1;
                rstn = 1'b0;
                #1;
                check_all_zero("midreset");
                q.delete();
                step();
                step();
                rstn = 1'b1;
                issue_load_only(s);
            end
            s.p1 = 8'(i);
            s.p2 = 8'(i);
            s.p3 = 8'(i);
            s.e1 = 25'(i) << 12;
            s.e2 = {(i != 0), 24'(2 * i)};
            s.e3 = 25'h0;
            drive_coefs(s);
            bus.pix_1    = s.p1;
            bus.pix_2    = s.p2;
            bus.pix_3    = s.p3;
            bus.ddata_in = 16'(i);
            bus.valid_in = (i % 2 == 0);
            if (i % 2 == 0) push(s, 16'(i));
            step();
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic issue_load_only(input vec_t v);
        drive_coefs(v);
        bus.coef_load = 1'b1;
        bus.valid_in  = 1'b0;
        step();
        bus.coef_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        bus.valid_in  = 1'b0;
        bus.pix_1     = '0;
        bus.pix_2     = '0;
        bus.pix_3     = '0;
        bus.coef_1    = '0;
        bus.coef_2    = '0;
        bus.coef_3    = '0;
        bus.offset    = '0;
        bus.coef_load = 1'b0;
        bus.ddata_in  = '0;

        tab[0] = '{8'h80, 17'h01000, 8'h80, 17'h11000, 8'hFF, 17'h0FFFF, 25'h0000000,
                   25'h0080000, 25'h1080000, 25'h0FEFF01, 25'h0000000};
        tab[1] = '{8'h00, 17'h1FFFF, 8'h00, 17'h11000, 8'h01, 17'h10001, 25'h1000000,
                   25'h0000000, 25'h0000000, 25'h1000001, 25'h0000000};
        tab[2] = '{8'hFF, 17'h1FFFF, 8'h12, 17'h00010, 8'h0F, 17'h00003, 25'h0ABCDEF,
                   25'h1FEFF01, 25'h0000120, 25'h000002D, 25'h0ABCDEF};
        tab[3] = '{8'hF0, 17'h00001, 8'h0F, 17'h10001, 8'h80, 17'h10000, 25'h1000001,
                   25'h00000F0, 25'h100000F, 25'h0000000, 25'h1000001};
        tab[4] = '{8'hA5, 17'h01234, 8'h3C, 17'h1ABCD, 8'h01, 17'h0FFFF, 25'h1FFFFFF,
                   25'h00BBB84, 25'h128440C, 25'h000FFFF, 25'h1FFFFFF};

        step();
        step();
        check_all_zero("reset");
        rstn = 1'b1;
        step();

        for (int k = 0; k < 5; k++) issue(tab[k], 1'b1, 16'hA000 + 16'(k));
        for (int k = 0; k < 4; k++) step();

        stream(16, -1);
        for (int k = 0; k < 4; k++) step();
        stream(16, 7);
        for (int k = 0; k < 4; k++) step();

`ifdef CSC_COEF_LATCH_EN
        begin
            vec_t l;
            l = '{8'h10, 17'h01000, 8'h00, 17'h0, 8'h00, 17'h0, 25'h0,
                  25'h0010000, 25'h0, 25'h0, 25'h0};
            issue(l, 1'b1, 16'hB000);
            l.c1 = 17'h02000;
            issue(l, 1'b0, 16'hB001);
            l.e1 = 25'h0020000;
            issue(l, 1'b1, 16'hB002);
            for (int k = 0; k < 4; k++) step();
        end
`endif

        check("scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
